// File: rtl/rv32i_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : rv32i_multicycle_ctrl
// Brief   : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I datapath.
// Revision: 1.0 - initial release
// ============================================================================
module rv32i_multicycle_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] instr,
  input  logic            branch_taken,
  input  logic            imem_ready,
  input  logic            dmem_ready,
  output logic            imem_req,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic            ir_we,
  output logic            pc_we,
  output logic [1:0]      pc_sel,
  output logic [1:0]      alu_a_sel,
  output logic            alu_b_sel,
  output logic [1:0]      wb_sel,
  output logic            reg_we,
  output logic            trap,
  output logic [XLEN-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_REG    = 7'b0110011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

  state_t          r_state;
  logic [6:0]      r_opcode;
  logic [XLEN-1:0] r_instret;
  logic            w_valid_op;
  logic            w_retire;
  logic            w_unused_instr_hi;

  // Only the opcode field matters to the sequencer.
  assign w_unused_instr_hi = ^instr[XLEN-1:7];

  always_comb begin
    w_valid_op = 1'b0;
    case (instr[6:0])
      c_OP_LOAD, c_OP_IMM, c_OP_STORE, c_OP_REG, c_OP_BRANCH,
      c_OP_JAL, c_OP_JALR, c_OP_LUI, c_OP_AUIPC: w_valid_op = 1'b1;
      default:                                   w_valid_op = 1'b0;
    endcase
  end

  // An instruction retires on its last cycle: branch EXEC, completed store, or WB.
  assign w_retire = ((r_state == S_EXEC) && (r_opcode == c_OP_BRANCH)) ||
                    ((r_state == S_MEM) && (r_opcode == c_OP_STORE) && dmem_ready) ||
                    (r_state == S_WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_opcode  <= 7'd0;
      r_instret <= '0;
    end else begin
      if (w_retire) r_instret <= r_instret + XLEN'(1);
      case (r_state)
        S_IDLE:   r_state <= S_FETCH;
        S_FETCH:  if (imem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          r_opcode <= instr[6:0];
          r_state  <= w_valid_op ? S_EXEC : S_TRAP;
        end
        S_EXEC: begin
          case (r_opcode)
            c_OP_BRANCH:          r_state <= S_FETCH;
            c_OP_LOAD, c_OP_STORE: r_state <= S_MEM;
            default:              r_state <= S_WB;
          endcase
        end
        S_MEM:    if (dmem_ready) r_state <= (r_opcode == c_OP_STORE) ? S_FETCH : S_WB;
        S_WB:     r_state <= S_FETCH;
        S_TRAP:   r_state <= S_TRAP;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'd0;
    alu_a_sel = 2'd0;
    alu_b_sel = 1'b0;
    wb_sel    = 2'd0;
    reg_we    = 1'b0;
    trap      = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
        pc_we    = imem_ready;
      end
      S_EXEC: begin
        case (r_opcode)
          c_OP_IMM, c_OP_LOAD, c_OP_STORE: alu_b_sel = 1'b1;
          c_OP_LUI: begin
            alu_a_sel = 2'd2;
            alu_b_sel = 1'b1;
          end
          c_OP_AUIPC: begin
            alu_a_sel = 2'd1;
            alu_b_sel = 1'b1;
          end
          c_OP_BRANCH: begin
            pc_we  = branch_taken;
            pc_sel = 2'd1;
          end
          c_OP_JAL: begin
            pc_we  = 1'b1;
            pc_sel = 2'd1;
          end
          c_OP_JALR: begin
            alu_b_sel = 1'b1;
            pc_we     = 1'b1;
            pc_sel    = 2'd2;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (r_opcode == c_OP_STORE);
      end
      S_WB: begin
        reg_we = 1'b1;
        if (r_opcode == c_OP_LOAD)
          wb_sel = 2'd1;
        else if ((r_opcode == c_OP_JAL) || (r_opcode == c_OP_JALR))
          wb_sel = 2'd2;
      end
      S_TRAP:  trap = 1'b1;
      default: ;
    endcase
  end

  assign instret = r_instret;

endmodule
`default_nettype wire

// File: doc/rv32i_multicycle_ctrl.md
# rv32i_multicycle_ctrl

Multi-cycle control sequencer for the RV32I datapath. Walks each instruction through FETCH, DECODE, EXEC, MEM and WB states, handshakes with instruction and data memory, and drives the datapath enables and mux selects. Sits beside the register file, ALU and immediate generator, and owns the retired-instruction counter.

## Interface
Parameters:
- `XLEN`, 32: datapath and counter width (equals `INSTRUCTION_SIZE`).

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `instr` in XLEN: instruction register contents, valid from DECODE onward.
- `branch_taken` in 1: ALU compare result, valid in EXEC.
- `imem_ready` in 1: instruction memory has returned data.
- `dmem_ready` in 1: data access is complete.
- `imem_req` out 1: fetch request.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: store (1) or load (0).
- `ir_we` out 1: latch the instruction and the old PC.
- `pc_we` out 1: PC write enable.
- `pc_sel` out 2: PC source. 0 = PC+4, 1 = old_pc+imm, 2 = ALU result with bit 0 cleared.
- `alu_a_sel` out 2: ALU operand A. 0 = rs1, 1 = old_pc, 2 = zero.
- `alu_b_sel` out 1: ALU operand B. 0 = rs2, 1 = imm.
- `wb_sel` out 2: write-back source. 0 = ALU, 1 = load data, 2 = old_pc+4.
- `reg_we` out 1: register file write.
- `trap` out 1: sticky illegal-instruction flag.
- `instret` out XLEN: count of retired instructions.

## Operation
- States are IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset value is IDLE.
- IDLE: all outputs 0. Goes to FETCH on the next cycle.
- FETCH: `imem_req`=1 until `imem_ready`=1. In the ready cycle: `ir_we`=1, `pc_we`=1, `pc_sel`=0, then go to DECODE.
- DECODE: one cycle. The opcode is `instr[6:0]`, latched internally.
  - Valid opcodes: 0000011, 0010011, 0100011, 0110011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - Any other opcode goes to TRAP.
- EXEC, by opcode:
  - R-type: `alu_a_sel`=0, `alu_b_sel`=0, then WB.
  - I-ALU: `alu_a_sel`=0, `alu_b_sel`=1, then WB.
  - Load and store: `alu_a_sel`=0, `alu_b_sel`=1, then MEM.
  - LUI: `alu_a_sel`=2, `alu_b_sel`=1, then WB.
  - AUIPC: `alu_a_sel`=1, `alu_b_sel`=1, then WB.
  - Branch: `alu_a_sel`=0, `alu_b_sel`=0, `pc_we`=`branch_taken`, `pc_sel`=1. Retires, then FETCH.
  - JAL: `pc_we`=1, `pc_sel`=1, then WB.
  - JALR: `alu_a_sel`=0, `alu_b_sel`=1, `pc_we`=1, `pc_sel`=2, then WB.
- MEM: `dmem_req`=1, with `dmem_we`=1 for stores. Held until `dmem_ready`.
  - Load: goes to WB.
  - Store: retires, then FETCH.
- WB: one cycle, `reg_we`=1. Retires, then FETCH.
  - `wb_sel`=1 for loads, 2 for JAL/JALR, 0 otherwise.
  - x0 suppression is done in the register file, not here.
- Retire: `instret` increments by 1 on the final cycle of an instruction. It wraps from 2^XLEN-1 to 0.
- TRAP: `trap`=1 and all other outputs 0. The state stays in TRAP until reset. A trapped instruction does not retire.
- Outputs are combinational decodes of the state register and the latched opcode. The `branch_taken`, `imem_ready` and `dmem_ready` inputs feed only the outputs named above.

## Timing
- Reset: asserting `rst_n` low immediately forces state IDLE, `instret`=0, and every output 0. This applies mid-instruction, including during an outstanding memory request. The request drops combinationally with no completion.
- Handshake: a request stays high and its attributes stay stable until the ready cycle. Ready is sampled at the rising edge only while the request is high; ready while the request is low is ignored.
- Minimum latency with ready held high (FETCH→retire):
  - Branch: 3 cycles.
  - ALU, LUI, AUIPC, JAL, JALR, store: 4 cycles.
  - Load: 5 cycles.
- Each wait cycle in FETCH or MEM adds exactly 1 cycle.
- Back-to-back: the cycle after a retire is FETCH, with `imem_req`=1.
- Reset release: the first `imem_req` is asserted 1 cycle after `rst_n` rises (the IDLE cycle).

## Test plan
- ADDI x1,x0,5 (0x00500093) with ready held high → states FETCH, DECODE, EXEC(`alu_b_sel`=1), WB(`reg_we`=1, `wb_sel`=0). `instret` goes 0→1 after 4 cycles.
- LW with `dmem_ready` low for 3 cycles → MEM holds `dmem_req`=1, `dmem_we`=0 for 4 cycles, then WB with `wb_sel`=1. Total 8 cycles.
- BEQ run twice, with `branch_taken`=1 then 0 → EXEC `pc_we`=1/`pc_sel`=1, then `pc_we`=0. No `reg_we` either time, and 3 cycles each.
- JALR (0x000080E7) → EXEC `pc_we`=1 with `pc_sel`=2, then WB with `wb_sel`=2 and `reg_we`=1.
- Opcode 0x0000007F → TRAP. `trap` stays 1 for 10 or more cycles, `instret` is unchanged, and `imem_req` stays 0.
- `rst_n` pulsed low mid-MEM of an SW → `dmem_req` is 0 at once and `instret`=0. After release: one IDLE cycle, then FETCH.
